// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the MemLPM arbiter: default widths, port indices
// and the layout of the read-return tag carried through the latency pipe.
package mem_arbiter_pkg;

  localparam int AW_DEFAULT     = 5;
  localparam int DW_DEFAULT     = 16;
  localparam int RD_LAT_DEFAULT = 1;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_CPU};

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Shift register of read-return tags, one stage per cycle of memory read
// latency, cleared synchronously while Resetn is low.
module rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    Clock,
  input  logic    Resetn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH:0] chain;

  assign chain[0] = tag_in;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      rd_tag_t tag_reg;

      always_ff @(posedge Clock) begin
        if (!Resetn) begin
          tag_reg <= TAG_IDLE;
        end else begin
          tag_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = tag_reg;
    end
  endgenerate

  assign tag_out = chain[DEPTH];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port MemLPM between the processor
// (port 0) and the board loader/debug port (port 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          owner
);

  logic    prio_reg;
  logic    gnt_valid;
  logic    gnt_port;
  logic    sel_we;
  logic    rd_done;
  rd_tag_t push_tag;
  rd_tag_t done_tag;

  always_comb begin
    gnt_valid = (p0_req | p1_req) & Resetn;
    gnt_port  = (p0_req & p1_req) ? prio_reg : p1_req;
    sel_we    = (gnt_port == PORT_LOADER) ? p1_we : p0_we;
  end

  assign p0_gnt = gnt_valid & (gnt_port == PORT_CPU);
  assign p1_gnt = gnt_valid & (gnt_port == PORT_LOADER);
  assign owner  = p1_gnt;

  // Idle cycles park the memory bus on port 0 with the write strobe low.
  assign mem_addr = p1_gnt ? p1_addr  : p0_addr;
  assign mem_data = p1_gnt ? p1_wdata : p0_wdata;
  assign mem_wren = gnt_valid & sel_we;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      prio_reg <= PORT_CPU;
    end else if (gnt_valid) begin
      prio_reg <= other_port(gnt_port);
    end
  end

  always_comb begin
    push_tag       = TAG_IDLE;
    push_tag.valid = gnt_valid & ~sel_we;
    push_tag.port  = gnt_port;
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .tag_in  (push_tag),
    .tag_out (done_tag)
  );

  // Gating with Resetn drops a read whose return lands in the reset cycle.
  assign rd_done   = done_tag.valid & Resetn;
  assign p0_rvalid = rd_done & (done_tag.port == PORT_CPU);
  assign p1_rvalid = rd_done & (done_tag.port == PORT_LOADER);
  assign p0_rdata  = mem_q;
  assign p1_rdata  = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT 1 and 2) each with a MemLPM
// model; read returns are checked by a scoreboard monitor on the falling edge.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 16;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic Clock = 1'b0;
  logic Resetn;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Instance A: RD_LAT = 1
  logic          a_p0_req, a_p0_we, a_p0_gnt, a_p0_rvalid;
  logic [AW-1:0] a_p0_addr;
  logic [DW-1:0] a_p0_wdata, a_p0_rdata;
  logic          a_p1_req, a_p1_we, a_p1_gnt, a_p1_rvalid;
  logic [AW-1:0] a_p1_addr;
  logic [DW-1:0] a_p1_wdata, a_p1_rdata;
  logic [AW-1:0] a_mem_addr;
  logic [DW-1:0] a_mem_data, a_mem_q;
  logic          a_mem_wren, a_owner;

  // Instance B: RD_LAT = 2
  logic          b_p0_req, b_p0_we, b_p0_gnt, b_p0_rvalid;
  logic [AW-1:0] b_p0_addr;
  logic [DW-1:0] b_p0_wdata, b_p0_rdata;
  logic          b_p1_req, b_p1_we, b_p1_gnt, b_p1_rvalid;
  logic [AW-1:0] b_p1_addr;
  logic [DW-1:0] b_p1_wdata, b_p1_rdata;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_data, b_mem_q;
  logic          b_mem_wren, b_owner;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_a (
    .Clock(Clock), .Resetn(Resetn),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_wren(a_mem_wren),
    .mem_q(a_mem_q), .owner(a_owner)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut_b (
    .Clock(Clock), .Resetn(Resetn),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
    .mem_q(b_mem_q), .owner(b_owner)
  );

  // MemLPM models: registered address/data/wren; B adds an output register.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic [AW-1:0] a_addr_q, b_addr_q;
  logic [DW-1:0] b_q_reg;

  always @(posedge Clock) begin
    if (a_mem_wren) mem_a[a_mem_addr] <= a_mem_data;
    a_addr_q <= a_mem_addr;
    if (b_mem_wren) mem_b[b_mem_addr] <= b_mem_data;
    b_addr_q <= b_mem_addr;
    b_q_reg  <= mem_b[b_addr_q];
  end

  assign a_mem_q = mem_a[a_addr_q];
  assign b_mem_q = b_q_reg;

  exp_t q_a0[$];
  exp_t q_a1[$];
  exp_t q_b0[$];
  exp_t q_b1[$];

  task automatic set_a(input logic r0, input logic w0, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
    a_p0_req = r0; a_p0_we = w0; a_p0_addr = ad0; a_p0_wdata = d0;
    a_p1_req = r1; a_p1_we = w1; a_p1_addr = ad1; a_p1_wdata = d1;
  endtask

  task automatic set_b(input logic r0, input logic w0, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
    b_p0_req = r0; b_p0_we = w0; b_p0_addr = ad0; b_p0_wdata = d0;
    b_p1_req = r1; b_p1_we = w1; b_p1_addr = ad1; b_p1_wdata = d1;
  endtask

  // Checks grant/owner/wren mid-cycle, queues the expected read return, then
  // advances to just after the next rising edge.
  task automatic step(input string name, input int dut, input logic eg0, input logic eg1,
                      input logic ewr, input logic push, input logic pport, input logic [DW-1:0] pdata);
    logic [3:0] act;
    logic [3:0] exp;
    exp_t       e;
    @(negedge Clock);
    if (dut == 0) act = {a_p0_gnt, a_p1_gnt, a_owner, a_mem_wren};
    else          act = {b_p0_gnt, b_p1_gnt, b_owner, b_mem_wren};
    exp = {eg0, eg1, eg1, ewr};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: {gnt0,gnt1,owner,wren} got %b want %b (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] %s: {gnt0,gnt1,owner,wren}=%b ok (cycle %0d)", name, act, cyc);
    end
    if (push) begin
      e.cyc  = cyc + ((dut == 0) ? 1 : 2);
      e.data = pdata;
      if (dut == 0) begin
        if (pport) q_a1.push_back(e); else q_a0.push_back(e);
      end else begin
        if (pport) q_b1.push_back(e); else q_b0.push_back(e);
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic mon(input string name, input logic rv, input logic [DW-1:0] rd,
                     input int qn, input int fcyc, input logic [DW-1:0] fdata, output logic pop);
    logic ev;
    pop = 1'b0;
    if (qn > 0 && fcyc < cyc) begin
      tests++;
      failed++;
      pop = 1'b1;
      $display("FAIL %s missed: rvalid never seen, required at cycle %0d data %h", name, fcyc, fdata);
    end
    ev = (qn > 0) && (fcyc == cyc);
    if (rv === 1'b1 || ev) begin
      tests++;
      if (rv !== ev) begin
        failed++;
        $display("FAIL %s rvalid: got %b want %b (cycle %0d)", name, rv, ev, cyc);
      end else if (rd !== fdata) begin
        failed++;
        $display("FAIL %s rdata: got %h want %h (cycle %0d)", name, rd, fdata, cyc);
      end else begin
        $display("[TB] %s read return %h ok (cycle %0d)", name, rd, cyc);
      end
    end
    if (ev) pop = 1'b1;
  endtask

  always @(negedge Clock) begin : monitor
    logic p;
    mon("a_p0", a_p0_rvalid, a_p0_rdata, q_a0.size(),
        (q_a0.size() > 0) ? q_a0[0].cyc : 0, (q_a0.size() > 0) ? q_a0[0].data : '0, p);
    if (p) void'(q_a0.pop_front());
    mon("a_p1", a_p1_rvalid, a_p1_rdata, q_a1.size(),
        (q_a1.size() > 0) ? q_a1[0].cyc : 0, (q_a1.size() > 0) ? q_a1[0].data : '0, p);
    if (p) void'(q_a1.pop_front());
    mon("b_p0", b_p0_rvalid, b_p0_rdata, q_b0.size(),
        (q_b0.size() > 0) ? q_b0[0].cyc : 0, (q_b0.size() > 0) ? q_b0[0].data : '0, p);
    if (p) void'(q_b0.pop_front());
    mon("b_p1", b_p1_rvalid, b_p1_rdata, q_b1.size(),
        (q_b1.size() > 0) ? q_b1[0].cyc : 0, (q_b1.size() > 0) ? q_b1[0].data : '0, p);
    if (p) void'(q_b1.pop_front());
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int left;
    Resetn = 1'b0;
    set_a(1, 1, 5'd1, 16'h0011, 1, 1, 5'd2, 16'h0022);
    set_b(0, 0, 5'd0, 16'h0000, 0, 0, 5'd0, 16'h0000);
    @(posedge Clock);
    #1;

    // Reset with both requesting writes: nothing may be granted or written.
    step("reset_c0", 0, 0, 0, 0, 0, 0, '0);
    step("reset_c1", 0, 0, 0, 0, 0, 0, '0);
    Resetn = 1'b1;
    step("release_p0_first", 0, 1, 0, 1, 0, 0, '0);
    set_a(0, 0, 5'd0, 16'h0000, 1, 1, 5'd2, 16'h0022);
    step("p1_wr_addr2", 0, 0, 1, 1, 0, 0, '0);

    // Single-port write then read of BEEF on port 1.
    set_a(0, 0, 5'd0, 16'h0000, 1, 1, 5'd5, 16'hBEEF);
    step("p1_wr_beef", 0, 0, 1, 1, 0, 0, '0);
    set_a(0, 0, 5'd0, 16'h0000, 1, 0, 5'd5, 16'h0000);
    step("p1_rd_beef", 0, 0, 1, 0, 1, 1, 16'hBEEF);
    set_a(0, 0, 5'd0, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("idle_0", 0, 0, 0, 0, 0, 0, '0);

    // Contention: alternating grants p0,p1,p0,p1.
    set_a(1, 0, 5'd1, 16'h0000, 1, 0, 5'd2, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("contend_%0d", i), 0, (i % 2) == 0, (i % 2) == 1, 0, 1,
           (i % 2) == 1, ((i % 2) == 1) ? 16'h0022 : 16'h0011);
    end

    // Priority holds across idle cycles.
    set_a(0, 0, 5'd0, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("idle_after_p1", 0, 0, 0, 0, 0, 0, '0);
    set_a(1, 0, 5'd1, 16'h0000, 1, 0, 5'd2, 16'h0000);
    step("tie_after_idle_p0", 0, 1, 0, 0, 1, 0, 16'h0011);
    set_a(0, 0, 5'd0, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("idle_after_p0", 0, 0, 0, 0, 0, 0, '0);
    set_a(1, 0, 5'd1, 16'h0000, 1, 0, 5'd2, 16'h0000);
    step("tie_after_idle_p1", 0, 0, 1, 0, 1, 1, 16'h0022);

    // Read-after-write on consecutive cycles, then ordered write/read race.
    set_a(1, 1, 5'd9, 16'h5555, 0, 0, 5'd0, 16'h0000);
    step("p0_wr_9_5555", 0, 1, 0, 1, 0, 0, '0);
    set_a(1, 1, 5'd7, 16'h1234, 0, 0, 5'd0, 16'h0000);
    step("p0_wr_7", 0, 1, 0, 1, 0, 0, '0);
    set_a(1, 0, 5'd7, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("p0_raw_7", 0, 1, 0, 0, 1, 0, 16'h1234);
    set_a(1, 1, 5'd9, 16'hAAAA, 1, 0, 5'd9, 16'h0000);
    step("race_p1_rd_first", 0, 0, 1, 0, 1, 1, 16'h5555);
    set_a(1, 1, 5'd9, 16'hAAAA, 0, 0, 5'd0, 16'h0000);
    step("race_p0_wr_second", 0, 1, 0, 1, 0, 0, '0);
    set_a(0, 0, 5'd0, 16'h0000, 1, 0, 5'd9, 16'h0000);
    step("p1_rd_9_new", 0, 0, 1, 0, 1, 1, 16'hAAAA);

    // Reset in the cycle after a granted read: that read must not return.
    set_a(1, 0, 5'd1, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("p0_rd_before_reset", 0, 1, 0, 0, 0, 0, '0);
    Resetn = 1'b0;
    set_a(1, 1, 5'd3, 16'h3333, 1, 0, 5'd2, 16'h0000);
    step("mid_reset_gated", 0, 0, 0, 0, 0, 0, '0);
    Resetn = 1'b1;
    set_a(1, 0, 5'd1, 16'h0000, 1, 0, 5'd2, 16'h0000);
    step("post_reset_p0", 0, 1, 0, 0, 1, 0, 16'h0011);
    step("post_reset_p1", 0, 0, 1, 0, 1, 1, 16'h0022);
    set_a(0, 0, 5'd0, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("idle_1", 0, 0, 0, 0, 0, 0, '0);

    // RD_LAT = 2 instance: preload via loader, then back-to-back reads.
    set_b(0, 0, 5'd0, 16'h0000, 1, 1, 5'd31, 16'hF00D);
    step("b_p1_wr_31", 1, 0, 1, 1, 0, 0, '0);
    set_b(0, 0, 5'd0, 16'h0000, 1, 1, 5'd30, 16'h3030);
    step("b_p1_wr_30", 1, 0, 1, 1, 0, 0, '0);
    set_b(1, 0, 5'd31, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("b_p0_rd_31", 1, 1, 0, 0, 1, 0, 16'hF00D);
    set_b(1, 0, 5'd30, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("b_p0_rd_30", 1, 1, 0, 0, 1, 0, 16'h3030);
    set_b(1, 0, 5'd31, 16'h0000, 0, 0, 5'd0, 16'h0000);
    step("b_p0_rd_31_again", 1, 1, 0, 0, 1, 0, 16'hF00D);
    set_b(0, 0, 5'd0, 16'h0000, 0, 0, 5'd0, 16'h0000);
    for (int i = 0; i < 4; i++) step($sformatf("b_idle_%0d", i), 1, 0, 0, 0, 0, 0, '0);

    left = q_a0.size() + q_a1.size() + q_b0.size() + q_b1.size();
    tests++;
    if (left != 0) begin
      failed++;
      $display("FAIL drain: %0d read returns outstanding, required 0", left);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
